ibuf_ctrl: RTL and testbench

Per-port input buffer and packet controller for the 5x5 router. Sits directly upstream of `rtcomp`: it stores arriving flits in a FIFO, presents each head flit's address and input VC to `rtcomp` for one cycle, and latches the returned output port and VC. It then requests the switch on the packet's behalf until the tail flit leaves, returning one credit upstream per flit dequeued.

---
 rtl/ibuf_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ibuf_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_ctrl.sv
// Per-port input buffer and packet controller: flit FIFO, one-cycle route compute, switch request until tail.
// Optional sticky overflow/orphan flag via IBUF_ERRCHK_EN.
`ifndef ENTRYW
`define ENTRYW 7
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef VCHW
`define VCHW 1
`endif

module ibuf_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATAW = 32
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                ivalid,
  input  logic [1:0]          itype,
  input  logic [DATAW-1:0]    idata,
  input  logic [`ENTRYW:0]    iivch,
  output logic                credit,
  output logic [`ENTRYW:0]    rc_addr,
  output logic [`ENTRYW:0]    rc_ivch,
  output logic                rc_en,
  input  logic [`PORTW:0]     rc_port,
  input  logic [`VCHW:0]      rc_ovch,
  output logic                sw_req,
  output logic [`PORTW:0]     sw_port,
  input  logic                sw_grant,
  output logic [1:0]          otype,
  output logic [DATAW-1:0]    odata,
  output logic [`VCHW:0]      ovch,
  output logic                empty,
`ifdef IBUF_ERRCHK_EN
  output logic                err,
`endif
  output logic                full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [1:0] FT_NONE = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RC     = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DATAW+1:0]     mem_q [DEPTH];
  logic [DATAW+1:0]     mem_d [DEPTH];
  logic [PW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [`ENTRYW:0]     ivch_q, ivch_d;
  logic [`PORTW:0]      port_q, port_d;
  logic [`VCHW:0]       ovch_q, ovch_d;
  logic                 credit_q, credit_d;
  logic                 wr, deq, discard;
  logic [DATAW+1:0]     head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign wr    = ivalid && (itype != FT_NONE) && !full;

  assign head    = mem_q[rd_ptr_q[PW-1:0]];
  assign otype   = head[DATAW+1:DATAW];
  assign odata   = head[DATAW-1:0];
  assign rc_addr = odata[`ENTRYW:0];
  assign rc_ivch = ivch_q;
  assign sw_port = port_q;
  assign ovch    = ovch_q;
  assign credit  = credit_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    ivch_d   = ivch_q;
    if (wr) begin
      mem_d[wr_ptr_q[PW-1:0]] = {itype, idata};
      wr_ptr_d                = wr_ptr_q + 1'b1;
      if (itype == FT_HEAD) ivch_d = iivch;
    end
  end

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    ovch_d   = ovch_q;
    rc_en    = 1'b0;
    sw_req   = 1'b0;
    deq      = 1'b0;
    discard  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (otype == FT_HEAD) begin
            state_d = RC;
          end else begin
            deq     = 1'b1;
            discard = 1'b1;
          end
        end
      end
      RC: begin
        rc_en   = 1'b1;
        port_d  = rc_port;
        ovch_d  = rc_ovch;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        sw_req = !empty;
        if (sw_grant && !empty) begin
          deq = 1'b1;
          if (otype == FT_TAIL) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, deq};
    credit_d = deq;
  end

`ifdef IBUF_ERRCHK_EN
  logic err_q, err_d;
  assign err = err_q;

  always_comb begin
    err_d = err_q | (ivalid && (itype != FT_NONE) && full) | discard;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ivch_q   <= '0;
      port_q   <= '0;
      ovch_q   <= '0;
      credit_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ivch_q   <= ivch_d;
      port_q   <= port_d;
      ovch_q   <= ovch_d;
      credit_q <= credit_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_ibuf_ctrl.sv
// Scoreboard bench for ibuf_ctrl with a behavioural XY route-compute model at node (1,1).
`ifndef ENTRYW
`define ENTRYW 7
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef VCHW
`define VCHW 1
`endif

module tb_ibuf_ctrl;
  localparam int DEPTH = 4;
  localparam int DATAW = 32;
  localparam logic [3:0] MY_X = 4'd1;
  localparam logic [3:0] MY_Y = 4'd1;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic              ivalid = 1'b0;
  logic [1:0]        itype = 2'b00;
  logic [DATAW-1:0]  idata = '0;
  logic [`ENTRYW:0]  iivch = '0;
  logic              sw_grant = 1'b0;
  logic              credit, rc_en, sw_req, empty, full;
  logic [`ENTRYW:0]  rc_addr, rc_ivch;
  logic [`PORTW:0]   rc_port, sw_port;
  logic [`VCHW:0]    rc_ovch, ovch;
  logic [1:0]        otype;
  logic [DATAW-1:0]  odata;
`ifdef IBUF_ERRCHK_EN
  logic              err;
`endif

  ibuf_ctrl #(.DEPTH(DEPTH), .DATAW(DATAW)) dut (
    .clk(clk), .rst_(rst_), .ivalid(ivalid), .itype(itype), .idata(idata), .iivch(iivch),
    .credit(credit), .rc_addr(rc_addr), .rc_ivch(rc_ivch), .rc_en(rc_en),
    .rc_port(rc_port), .rc_ovch(rc_ovch), .sw_req(sw_req), .sw_port(sw_port),
    .sw_grant(sw_grant), .otype(otype), .odata(odata), .ovch(ovch), .empty(empty),
`ifdef IBUF_ERRCHK_EN
    .err(err),
`endif
    .full(full)
  );

  always #5 clk = ~clk;

  // XY routing: east=1, north=2, west=3, south=0, local=4; output VC follows input VC
  logic [3:0] dst_x, dst_y;
  assign dst_x   = rc_addr[3:0];
  assign dst_y   = rc_addr[7:4];
  assign rc_port = (dst_x > MY_X) ? 3'd1 : (dst_x < MY_X) ? 3'd3 :
                   (dst_y > MY_Y) ? 3'd2 : (dst_y < MY_Y) ? 3'd0 : 3'd4;
  assign rc_ovch = rc_ivch[1:0];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] ivch;
  } rc_t;
  typedef struct packed {
    logic [2:0]  port;
    logic [1:0]  vch;
    logic [1:0]  typ;
    logic [31:0] data;
  } fl_t;

  rc_t rc_q[$];
  fl_t fl_q[$];
  int  rc_cyc_log[$];
  int  tail_cyc_log[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  credit_cnt = 0;
  int  rc_cnt = 0;
  int  head_g_cyc = 0;
  int  tail_g_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a route request or dequeues a granted flit
  always @(negedge clk) begin
    if (rst_) begin
      if (credit) credit_cnt++;
      if (rc_en) begin
        rc_cnt++;
        rc_cyc_log.push_back(cyc);
        if (rc_q.size() == 0) begin
          chk("rc_unexpected", 1, 0);
        end else begin
          rc_t e;
          e = rc_q.pop_front();
          chk("rc_addr", rc_addr, e.addr);
          chk("rc_ivch", rc_ivch, e.ivch);
        end
      end
      if (sw_req && sw_grant) begin
        if (otype == 2'b01) head_g_cyc = cyc;
        if (otype == 2'b11) begin
          tail_g_cyc = cyc;
          tail_cyc_log.push_back(cyc);
        end
        if (fl_q.size() == 0) begin
          chk("flit_unexpected", 1, 0);
        end else begin
          fl_t f;
          f = fl_q.pop_front();
          chk("sw_port", sw_port, f.port);
          chk("ovch", ovch, f.vch);
          chk("otype", otype, f.typ);
          chk("odata", odata, f.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] d, input logic [7:0] v);
    ivalid = 1'b1; itype = t; idata = d; iivch = v;
    tick();
    ivalid = 1'b0; itype = 2'b00;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((fl_q.size() != 0 || rc_q.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    tick(); tick();
    chk("drain_flits", fl_q.size(), 0);
    chk("drain_rc", rc_q.size(), 0);
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!sw_req && n < maxc) begin
      tick();
      n++;
    end
    chk("sw_req_seen", sw_req, 1);
  endtask

  task automatic pulse_reset();
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
    $fatal(1);
  end

  initial begin
    int base, k, rc0;

    // Reset values, during and after reset
    tick(); tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_sw_req", sw_req, 0);
    rst_ = 1'b1;
    tick();
    chk("idle_empty", empty, 1);
    chk("idle_full", full, 0);
    chk("idle_credit", credit, 0);
    chk("idle_rc_en", rc_en, 0);
    chk("idle_sw_req", sw_req, 0);
    chk("idle_sw_port", sw_port, 0);
    chk("idle_ovch", ovch, 0);
    chk("idle_rc_ivch", rc_ivch, 0);
`ifdef IBUF_ERRCHK_EN
    chk("idle_err", err, 0);
`endif

    // 3-flit packet to (3,2) on VC1, grant tied high
    sw_grant = 1'b1;
    base = credit_cnt;
    rc0 = rc_cnt;
    rc_cyc_log.delete();
    rc_q.push_back('{addr: 8'h23, ivch: 8'h01});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b01, data: 32'h0000_0023});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b10, data: 32'h0000_B0B0});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b11, data: 32'h0000_7A17});
    k = cyc;
    send(2'b01, 32'h0000_0023, 8'h01);
    send(2'b10, 32'h0000_B0B0, 8'h00);
    send(2'b11, 32'h0000_7A17, 8'h00);
    wait_drain(20);
    chk("p1_credits", credit_cnt - base, 3);
    chk("p1_rc_once", rc_cnt - rc0, 1);
    chk("p1_rc_cycle", (rc_cyc_log.size() > 0) ? rc_cyc_log[0] - k : -1, 2);
    chk("p1_first_grant", head_g_cyc - k, 3);
    chk("p1_consecutive", tail_g_cyc - head_g_cyc, 2);

    // Local-destination packet held without grant
    sw_grant = 1'b0;
    base = credit_cnt;
    rc_q.push_back('{addr: 8'h11, ivch: 8'h02});
    fl_q.push_back('{port: 3'd4, vch: 2'd2, typ: 2'b01, data: 32'h0000_0011});
    fl_q.push_back('{port: 3'd4, vch: 2'd2, typ: 2'b11, data: 32'h0000_0000});
    send(2'b01, 32'h0000_0011, 8'h02);
    send(2'b11, 32'h0000_0000, 8'h00);
    wait_req(10);
    for (int i = 0; i < 5; i++) begin
      chk("hold_sw_req", sw_req, 1);
      chk("hold_sw_port", sw_port, 4);
      tick();
    end
    chk("hold_no_credit", credit_cnt - base, 0);
    chk("hold_queue", fl_q.size(), 2);
    sw_grant = 1'b1;
    wait_drain(20);
    chk("local_credits", credit_cnt - base, 2);

    // Fill the FIFO, then overflow by one
    sw_grant = 1'b0;
    base = credit_cnt;
    rc_q.push_back('{addr: 8'h23, ivch: 8'h01});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b01, data: 32'h0000_0023});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b10, data: 32'h0000_0001});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b10, data: 32'h0000_0002});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b11, data: 32'h0000_0003});
    send(2'b01, 32'h0000_0023, 8'h01);
    send(2'b10, 32'h0000_0001, 8'h00);
    send(2'b10, 32'h0000_0002, 8'h00);
    send(2'b11, 32'h0000_0003, 8'h00);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    send(2'b10, 32'h0000_0005, 8'h00);
    chk("ovf_full", full, 1);
`ifdef IBUF_ERRCHK_EN
    chk("ovf_err", err, 1);
`endif
    sw_grant = 1'b1;
    wait_drain(20);
    tick(); tick(); tick();
    chk("ovf_credits", credit_cnt - base, 4);
    chk("ovf_empty", empty, 1);
    pulse_reset();
`ifdef IBUF_ERRCHK_EN
    chk("err_cleared", err, 0);
`endif

    // Back-to-back 2-flit packets to different destinations
    sw_grant = 1'b1;
    base = credit_cnt;
    rc_cyc_log.delete();
    tail_cyc_log.delete();
    rc_q.push_back('{addr: 8'h23, ivch: 8'h01});
    rc_q.push_back('{addr: 8'h10, ivch: 8'h00});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b01, data: 32'h0000_0023});
    fl_q.push_back('{port: 3'd1, vch: 2'd1, typ: 2'b11, data: 32'h0000_AAAA});
    fl_q.push_back('{port: 3'd3, vch: 2'd0, typ: 2'b01, data: 32'h0000_0010});
    fl_q.push_back('{port: 3'd3, vch: 2'd0, typ: 2'b11, data: 32'h0000_BBBB});
    send(2'b01, 32'h0000_0023, 8'h01);
    send(2'b11, 32'h0000_AAAA, 8'h00);
    send(2'b01, 32'h0000_0010, 8'h00);
    send(2'b11, 32'h0000_BBBB, 8'h00);
    wait_drain(30);
    chk("b2b_credits", credit_cnt - base, 4);
    chk("b2b_rc_gap", (rc_cyc_log.size() > 1 && tail_cyc_log.size() > 0) ?
        rc_cyc_log[1] - tail_cyc_log[0] : -1, 2);

    // Orphan body flit in IDLE is discarded with a credit
    base = credit_cnt;
    rc0 = rc_cnt;
    send(2'b10, 32'h0000_DEAD, 8'h00);
    tick(); tick(); tick();
    chk("orphan_credit", credit_cnt - base, 1);
    chk("orphan_no_rc", rc_cnt - rc0, 0);
    chk("orphan_empty", empty, 1);
`ifdef IBUF_ERRCHK_EN
    chk("orphan_err", err, 1);
`endif
    pulse_reset();

    // Reset mid-packet with two flits buffered
    sw_grant = 1'b0;
    rc_q.push_back('{addr: 8'h23, ivch: 8'h01});
    send(2'b01, 32'h0000_0023, 8'h01);
    send(2'b10, 32'h0000_0042, 8'h00);
    wait_req(10);
    base = credit_cnt;
    #1;
    rst_ = 1'b0;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_sw_req", sw_req, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_credit", credit, 0);
    tick();
    rst_ = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_no_credit", credit_cnt - base, 0);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_rc_en", rc_en, 0);

    chk("final_flit_queue", fl_q.size(), 0);
    chk("final_rc_queue", rc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
